// File: rtl/cu_pkg.sv
// Shared constants for the control unit: opcodes, FSM states, strobe bits.
// CU_BRANCH_EN enables the br opcode in control_unit.
package cu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    RST, F0, F1, F2, T3, T4, T5, T6, T7, HALT
  } state_e;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_ADDI,
    C_BR, C_NOP, C_HALT, C_BAD
  } op_class_e;

  localparam int CTL_W = 35;

  localparam int S_PCOUT     = 0;
  localparam int S_ZLOWOUT   = 1;
  localparam int S_ZHIGHOUT  = 2;
  localparam int S_MDROUT    = 3;
  localparam int S_COUT      = 4;
  localparam int S_INPORTOUT = 5;
  localparam int S_LOOUT     = 6;
  localparam int S_HIOUT     = 7;
  localparam int S_MARIN     = 8;
  localparam int S_PCIN      = 9;
  localparam int S_MDRIN     = 10;
  localparam int S_IRIN      = 11;
  localparam int S_YIN       = 12;
  localparam int S_INCPC     = 13;
  localparam int S_HIIN      = 14;
  localparam int S_LOIN      = 15;
  localparam int S_CIN       = 16;
  localparam int S_ININ      = 17;
  localparam int S_OUTIN     = 18;
  localparam int S_ZIN       = 19;
  localparam int S_CONIN     = 20;
  localparam int S_GRA       = 21;
  localparam int S_GRB       = 22;
  localparam int S_GRC       = 23;
  localparam int S_RIN       = 24;
  localparam int S_ROUT      = 25;
  localparam int S_BAOUT     = 26;
  localparam int S_ADD       = 27;
  localparam int S_SUB       = 28;
  localparam int S_MUL       = 29;
  localparam int S_DIV       = 30;
  localparam int S_AND       = 31;
  localparam int S_OR        = 32;
  localparam int S_READ      = 33;
  localparam int S_WRITE     = 34;

endpackage

// File: rtl/control_unit.sv
// Hardwired multi-cycle control unit with registered strobes.
// Define CU_BRANCH_EN to implement the br opcode.
module control_unit
  import cu_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  input  logic             mem_ready,
  output logic [CTL_W-1:0] ctl,
  output logic             run,
  output logic             illegal_op
);

  state_e           state_q, state_d;
  logic             armed_q, armed_d;
  logic [CTL_W-1:0] ctl_q, ctl_d;
  logic             run_q, run_d;
  logic             ill_q, ill_d;
  logic [4:0]       op;
  op_class_e        cls;
  logic             unused_ir;

  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];

  function automatic op_class_e classify(
    input logic [4:0] o
  );
    case (o)
      OP_LD:   classify = C_LD;
      OP_LDI:  classify = C_LDI;
      OP_ST:   classify = C_ST;
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR:   classify = C_ALU;
      OP_ADDI: classify = C_ADDI;
`ifdef CU_BRANCH_EN
      OP_BR:   classify = C_BR;
`endif
      OP_NOP:  classify = C_NOP;
      OP_HALT: classify = C_HALT;
      default: classify = C_BAD;
    endcase
  endfunction

  // Strobes are computed for the state being entered, so the
  // ir opcode must be valid by the F2->T3 edge.
  function automatic logic [CTL_W-1:0] strobes(
    input state_e    s,
    input op_class_e c,
    input logic [4:0] o,
    input logic      cf
  );
    logic [CTL_W-1:0] v;
    v = '0;
    unique case (s)
      F0: begin
        v[S_PCOUT] = 1'b1;
        v[S_MARIN] = 1'b1;
        v[S_INCPC] = 1'b1;
        v[S_ZIN]   = 1'b1;
      end
      F1: begin
        v[S_ZLOWOUT] = 1'b1;
        v[S_PCIN]    = 1'b1;
        v[S_READ]    = 1'b1;
        v[S_MDRIN]   = 1'b1;
      end
      F2: begin
        v[S_MDROUT] = 1'b1;
        v[S_IRIN]   = 1'b1;
      end
      T3: begin
        case (c)
          C_LD, C_LDI, C_ST: begin
            v[S_GRB]   = 1'b1;
            v[S_BAOUT] = 1'b1;
            v[S_YIN]   = 1'b1;
          end
          C_ALU, C_ADDI: begin
            v[S_GRB]  = 1'b1;
            v[S_ROUT] = 1'b1;
            v[S_YIN]  = 1'b1;
          end
          C_BR: begin
            v[S_GRA]   = 1'b1;
            v[S_ROUT]  = 1'b1;
            v[S_CONIN] = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        case (c)
          C_LD, C_LDI, C_ST, C_ADDI: begin
            v[S_COUT] = 1'b1;
            v[S_ADD]  = 1'b1;
            v[S_ZIN]  = 1'b1;
          end
          C_ALU: begin
            v[S_GRC]  = 1'b1;
            v[S_ROUT] = 1'b1;
            v[S_ZIN]  = 1'b1;
            case (o)
              OP_SUB:  v[S_SUB] = 1'b1;
              OP_AND:  v[S_AND] = 1'b1;
              OP_OR:   v[S_OR]  = 1'b1;
              default: v[S_ADD] = 1'b1;
            endcase
          end
          C_BR: begin
            v[S_PCOUT] = 1'b1;
            v[S_YIN]   = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (c)
          C_LD, C_ST: begin
            v[S_ZLOWOUT] = 1'b1;
            v[S_MARIN]   = 1'b1;
          end
          C_LDI, C_ALU, C_ADDI: begin
            v[S_ZLOWOUT] = 1'b1;
            v[S_GRA]     = 1'b1;
            v[S_RIN]     = 1'b1;
          end
          C_BR: begin
            v[S_COUT] = 1'b1;
            v[S_ADD]  = 1'b1;
            v[S_ZIN]  = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        case (c)
          C_LD: begin
            v[S_READ]  = 1'b1;
            v[S_MDRIN] = 1'b1;
          end
          C_ST: begin
            v[S_GRA]   = 1'b1;
            v[S_ROUT]  = 1'b1;
            v[S_MDRIN] = 1'b1;
          end
          C_BR: begin
            v[S_ZLOWOUT] = cf;
            v[S_PCIN]    = cf;
          end
          default: ;
        endcase
      end
      T7: begin
        case (c)
          C_LD: begin
            v[S_MDROUT] = 1'b1;
            v[S_GRA]    = 1'b1;
            v[S_RIN]    = 1'b1;
          end
          C_ST: v[S_WRITE] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    return v;
  endfunction

  always_comb begin
    cls     = classify(op);
    state_d = state_q;
    armed_d = 1'b1;
    unique case (state_q)
      RST: state_d = armed_q ? F0 : RST;
      F0:  state_d = F1;
      F1:  if (mem_ready) state_d = F2;
      F2:  state_d = T3;
      T3: begin
        case (cls)
          C_NOP, C_BAD: state_d = F0;
          C_HALT:       state_d = HALT;
          default:      state_d = T4;
        endcase
      end
      T4:  state_d = T5;
      T5: begin
        case (cls)
          C_LD, C_ST, C_BR: state_d = T6;
          default:          state_d = F0;
        endcase
      end
      T6: begin
        case (cls)
          C_LD:    if (mem_ready) state_d = T7;
          C_ST:    state_d = T7;
          default: state_d = F0;
        endcase
      end
      T7: begin
        if (cls != C_ST || mem_ready) state_d = F0;
      end
      HALT: state_d = HALT;
      default: state_d = RST;
    endcase
    ctl_d = strobes(state_d, cls, op, con_ff);
    run_d = (state_d != HALT);
    ill_d = ill_q | ((state_d == T3) && (cls == C_BAD));
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= RST;
      armed_q <= 1'b0;
      ctl_q   <= '0;
      run_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      ctl_q   <= ctl_d;
      run_q   <= run_d;
      ill_q   <= ill_d;
    end
  end

  assign ctl        = ctl_q;
  assign run        = run_q;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit.
// Branch checks follow CU_BRANCH_EN.
module tb_control_unit;
  import cu_pkg::*;

  logic             clk;
  logic             clr;
  logic [31:0]      ir;
  logic             con_ff;
  logic             mem_ready;
  logic [CTL_W-1:0] ctl;
  logic             run;
  logic             illegal_op;

  int n_cmp = 0;
  int n_bad = 0;

  control_unit dut (
    .clk        (clk),
    .clr        (clr),
    .ir         (ir),
    .con_ff     (con_ff),
    .mem_ready  (mem_ready),
    .ctl        (ctl),
    .run        (run),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CTL_W-1:0] v(
    input int a = -1, input int b = -1,
    input int c = -1, input int d = -1
  );
    int l[4];
    logic [CTL_W-1:0] r;
    l = '{a, b, c, d};
    r = '0;
    foreach (l[i])
      if (l[i] >= 0) r = r | (CTL_W'(1) << l[i]);
    return r;
  endfunction

  task automatic chk_ctl(input string tag, input logic [CTL_W-1:0] e);
    n_cmp++;
    assert (ctl === e) else begin
      n_bad++;
      $error("FAIL %s: ctl=%h expected %h", tag, ctl, e);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic e);
    n_cmp++;
    assert (got === e) else begin
      n_bad++;
      $error("FAIL %s: got %b expected %b", tag, got, e);
    end
  endtask

  task automatic step(input string tag, input logic [CTL_W-1:0] e);
    @(posedge clk);
    #1;
    chk_ctl(tag, e);
  endtask

  task automatic set_op(input logic [4:0] o);
    ir = {o, 27'h0123456};
  endtask

  logic [CTL_W-1:0] VF0, VF1, VF2, VLDT3, VRT3, VCADD, VWB;

  initial begin
    VF0   = v(S_PCOUT, S_MARIN, S_INCPC, S_ZIN);
    VF1   = v(S_ZLOWOUT, S_PCIN, S_READ, S_MDRIN);
    VF2   = v(S_MDROUT, S_IRIN);
    VLDT3 = v(S_GRB, S_BAOUT, S_YIN);
    VRT3  = v(S_GRB, S_ROUT, S_YIN);
    VCADD = v(S_COUT, S_ADD, S_ZIN);
    VWB   = v(S_ZLOWOUT, S_GRA, S_RIN);

    clr = 1'b0; mem_ready = 1'b1; con_ff = 1'b0;
    set_op(OP_LD);
    #1;
    for (int i = 0; i < 3; i++) begin
      step("rst_ctl", '0);
      chk_bit("rst_run", run, 1'b0);
      chk_bit("rst_ill", illegal_op, 1'b0);
    end
    clr = 1'b1;
    step("rst_state", '0);
    chk_bit("rst_state_run", run, 1'b1);
    step("ld_f0", VF0);

    step("ld_f1", VF1);
    step("ld_f2", VF2);
    step("ld_t3", VLDT3);
    step("ld_t4", VCADD);
    step("ld_t5", v(S_ZLOWOUT, S_MARIN));
    step("ld_t6", v(S_READ, S_MDRIN));
    step("ld_t7", v(S_MDROUT, S_GRA, S_RIN));
    step("ld_c9_f0", VF0);

    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("ldw_f1", VF1);
    step("ldw_f1_4", VF1);
    mem_ready = 1'b1;
    step("ldw_f2", VF2);
    step("ldw_t3", VLDT3);
    step("ldw_t4", VCADD);
    step("ldw_t5", v(S_ZLOWOUT, S_MARIN));
    mem_ready = 1'b0;
    step("ldw_t6_1", v(S_READ, S_MDRIN));
    step("ldw_t6_2", v(S_READ, S_MDRIN));
    step("ldw_t6_3", v(S_READ, S_MDRIN));
    mem_ready = 1'b1;
    step("ldw_t7", v(S_MDROUT, S_GRA, S_RIN));
    step("ldw_f0", VF0);

    set_op(OP_LDI);
    step("ldi_f1", VF1);
    step("ldi_f2", VF2);
    step("ldi_t3", VLDT3);
    step("ldi_t4", VCADD);
    step("ldi_t5", VWB);
    step("ldi_f0", VF0);

    set_op(OP_ADD);
    step("add_f1", VF1);
    step("add_f2", VF2);
    step("add_t3", VRT3);
    step("add_t4", v(S_GRC, S_ROUT, S_ZIN, S_ADD));
    step("add_t5", VWB);
    step("add_f0", VF0);

    set_op(OP_OR);
    repeat (3) @(posedge clk);
    #1;
    step("or_t4", v(S_GRC, S_ROUT, S_ZIN, S_OR));
    step("or_t5", VWB);
    step("or_f0", VF0);

    set_op(OP_AND);
    repeat (3) @(posedge clk);
    #1;
    step("and_t4", v(S_GRC, S_ROUT, S_ZIN, S_AND));
    step("and_t5", VWB);
    step("and_f0", VF0);

    set_op(OP_ADDI);
    step("addi_f1", VF1);
    step("addi_f2", VF2);
    step("addi_t3", VRT3);
    step("addi_t4", VCADD);
    step("addi_t5", VWB);
    step("addi_f0", VF0);

    set_op(OP_NOP);
    step("nop_f1", VF1);
    step("nop_f2", VF2);
    step("nop_t3", '0);
    chk_bit("nop_ill", illegal_op, 1'b0);
    step("nop_f0", VF0);

`ifdef CU_BRANCH_EN
    set_op(OP_BR);
    con_ff = 1'b1;
    step("br1_f1", VF1);
    step("br1_f2", VF2);
    step("br1_t3", v(S_GRA, S_ROUT, S_CONIN));
    step("br1_t4", v(S_PCOUT, S_YIN));
    step("br1_t5", VCADD);
    step("br1_t6", v(S_ZLOWOUT, S_PCIN));
    step("br1_f0", VF0);
    con_ff = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    step("br0_t6", '0);
    step("br0_f0", VF0);
    chk_bit("br_ill", illegal_op, 1'b0);
`else
    set_op(OP_BR);
    step("br_f1", VF1);
    step("br_f2", VF2);
    step("br_t3", '0);
    chk_bit("br_ill", illegal_op, 1'b1);
    step("br_f0", VF0);
`endif

    set_op(5'b11111);
    step("bad_f1", VF1);
    step("bad_f2", VF2);
    step("bad_t3", '0);
    chk_bit("bad_ill", illegal_op, 1'b1);
    step("bad_f0", VF0);
    chk_bit("bad_ill_sticky", illegal_op, 1'b1);

    set_op(OP_ST);
    step("st_f1", VF1);
    step("st_f2", VF2);
    step("st_t3", VLDT3);
    step("st_t4", VCADD);
    step("st_t5", v(S_ZLOWOUT, S_MARIN));
    mem_ready = 1'b0;
    step("st_t6", v(S_GRA, S_ROUT, S_MDRIN));
    step("st_t7", v(S_WRITE));
    step("st_t7_hold", v(S_WRITE));
    #2;
    clr = 1'b0;
    #1;
    chk_ctl("st_abort_ctl", '0);
    chk_bit("st_abort_ill", illegal_op, 1'b0);
    chk_bit("st_abort_run", run, 1'b0);
    step("st_abort_hold", '0);
    clr = 1'b1;
    mem_ready = 1'b1;
    set_op(OP_SUB);
    step("st_rst", '0);
    chk_bit("st_rst_run", run, 1'b1);
    step("st_f0", VF0);

    step("sub_f1", VF1);
    step("sub_f2", VF2);
    step("sub_t3", VRT3);
    step("sub_t4", v(S_GRC, S_ROUT, S_SUB, S_ZIN));
    step("sub_t5", VWB);
    step("sub_f0", VF0);

    set_op(OP_HALT);
    step("halt_f1", VF1);
    step("halt_f2", VF2);
    step("halt_t3", '0);
    chk_bit("halt_t3_run", run, 1'b1);
    for (int i = 0; i < 22; i++) begin
      step("halt_ctl", '0);
      chk_bit("halt_run", run, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The port list SHALL be, clock and reset first:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- ir  in  32  instruction register contents; opcode is ir[31:27].
- con_ff  in  1  branch condition flip-flop output.
- mem_ready  in  1  memory done for the current read or write.
- ctl  out  n  registered datapath strobes, one bit each: PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout, MARIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn, Gra, Grb, Grc, RIn, Rout, BAout, add, subtract, multiply, divide, andSignal, orSignal, read, write.
- run  out  1  high while executing; low in HALT.
- illegal_op  out  1  sticky flag, set on an undefined opcode.

Function
REQ-002 All outputs SHALL be registered; strobes for state S SHALL be high exactly during the cycles in which the FSM is in S.
REQ-003 Every strobe not listed for a state SHALL be 0 in that state.
REQ-004 After reset release the FSM SHALL spend one cycle in RST, with all strobes 0 and run=1, then go to F0.
REQ-005 Fetch states:
- F0: PCout, MARIn, IncPC, ZIn.
- F1: Zlowout, PCIn, read, MDRIn.
- F2: MDRout, IRIn.
REQ-006 F1 SHALL hold, with identical strobes, while mem_ready=0, and SHALL advance to F2 on the cycle after mem_ready=1; reloading the PC from an unchanged Z is required to be idempotent.
REQ-007 From F2 the FSM SHALL go to T3 and decode ir[31:27] latched by IRIn.
REQ-008 ld: T3 Grb, BAout, YIn; T4 Cout, add, ZIn; T5 Zlowout, MARIn; T6 read, MDRIn (held while mem_ready=0); T7 MDRout, Gra, RIn; then F0.
REQ-009 ldi: T3 and T4 as ld; T5 Zlowout, Gra, RIn; then F0.
REQ-010 st: T3–T5 as ld; T6 Gra, Rout, MDRIn; T7 write (held while mem_ready=0); then F0.
REQ-011 add, sub, and, or: T3 Grb, Rout, YIn; T4 Grc, Rout, ZIn, plus one of add/subtract/andSignal/orSignal; T5 Zlowout, Gra, RIn; then F0.
REQ-012 addi: T3 Grb, Rout, YIn; T4 Cout, add, ZIn; T5 Zlowout, Gra, RIn; then F0.
REQ-013 nop: from T3 directly to F0 with no strobes.
REQ-014 halt: go to HALT, drive all strobes 0 and run=0, and stay there until reset.
REQ-015 Undefined opcode: set illegal_op, drive no strobes in T3, then F0; illegal_op SHALL stay set until reset.
REQ-016 At most one ALU-op strobe SHALL be high in any cycle; read and write SHALL never be high together.

Reset
REQ-017 While clr=0, asynchronously: state=RST, all strobes 0, run=0, illegal_op=0.
REQ-018 Reset asserted mid-instruction, including during a memory wait, SHALL abort immediately; execution resumes from F0 after reset release, with no partial register or memory write.

Configuration
REQ-019 Macro CU_BRANCH_EN:
- When defined, opcode br is implemented: T3 Gra, Rout, CONIn; T4 PCout, YIn; T5 Cout, add, ZIn; T6 Zlowout, PCIn only if con_ff=1, otherwise no strobes; then F0.
- When undefined, br SHALL be treated as undefined per REQ-015.

Structure
REQ-020 A shared package cu_pkg SHALL hold:
- the opcode constants: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, br=10010, nop=11010, halt=11011;
- the state enumeration: RST, F0, F1, F2, T3–T7, HALT;
- the strobe-vector bit indices.
REQ-021 The block SHALL be a single module with no sub-modules; decode and the next-state/output logic stay internal.

Verification
REQ-022 Reset: clr=0 for 3 cycles -> all strobes 0 and run=0; on release -> RST for 1 cycle, then F0 with PCout, MARIn, IncPC, ZIn =1.
REQ-023 ld, mem_ready always 1 -> strobe trace per REQ-005/REQ-008, 8 cycles F0..T7, back in F0 on cycle 9.
REQ-024 ld with mem_ready=0 for 3 cycles in F1 and 2 cycles in T6 -> F1 lasts 4 cycles and T6 lasts 3 with strobes unchanged; total 13 cycles.
REQ-025 sub, then halt -> T4 shows Grc, Rout, subtract, ZIn only; halt then drives run=0 and the FSM stays in HALT for 20 or more cycles.
REQ-026 br with CU_BRANCH_EN defined:
- con_ff=1 -> T6 shows Zlowout=1 and PCIn=1.
- con_ff=0 -> T6 has all strobes 0.
- With the macro undefined -> illegal_op=1.
REQ-027 clr dropped during st T7 with write=1 -> write goes to 0 asynchronously in the same cycle, illegal_op=0; after release, RST is followed by F0.
